// File: rtl/mc_ctrl.sv
// Multicycle IF/ID/EXE/MEM/WB control FSM for the simple MIPS core.
// Only state and the retired-instruction counter are registered; all controls decode combinationally.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  logic [2:0] state_q, state_d;
  ctrl_t      c, co;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_exe;
  assign is_addu = (opcode == OP_R) && (funct == FN_ADDU);
  assign is_subu = (opcode == OP_R) && (funct == FN_SUBU);
  assign is_jr   = (opcode == OP_R) && (funct == FN_JR);
  assign is_ori  = (opcode == OP_ORI);
  assign is_lui  = (opcode == OP_LUI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_exe  = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq;

  always_comb begin
    c       = '0;
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        c.mem_req = 1'b1;
        state_d   = S_IF;
        if (mem_ready) begin
          c.ir_we = 1'b1;
          c.pc_we = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          c.pc_we      = 1'b1;
          c.npc_sel    = 2'd2;
          c.instr_done = 1'b1;
          if (opcode == OP_JAL) begin
            c.reg_we  = 1'b1;
            c.reg_dst = 2'd2;
            c.wb_sel  = 2'd2;
          end
        end else if (is_exe) begin
          state_d = S_EXE;
        end else begin
          c.instr_done = 1'b1;
        end
      end
      S_EXE: begin
        if (is_addu) begin
          state_d = S_WB;
        end else if (is_subu) begin
          c.alu_op = 2'd1;
          state_d  = S_WB;
        end else if (is_ori) begin
          c.alu_op  = 2'd2;
          c.alu_src = 1'b1;
          state_d   = S_WB;
        end else if (is_lui) begin
          c.alu_op  = 2'd3;
          c.alu_src = 1'b1;
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          c.alu_src = 1'b1;
          state_d   = S_MEM;
        end else if (is_beq) begin
          c.alu_op     = 2'd1;
          c.pc_we      = zero;
          c.npc_sel    = 2'd1;
          c.instr_done = 1'b1;
        end else if (is_jr) begin
          c.pc_we      = 1'b1;
          c.npc_sel    = 2'd3;
          c.instr_done = 1'b1;
        end
      end
      S_MEM: begin
        // Address stays on the ALU for the whole wait so memory sees a stable request.
        c.mem_req = 1'b1;
        c.mem_we  = is_sw;
        c.alu_src = 1'b1;
        state_d   = S_MEM;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            c.instr_done = is_sw;
            state_d      = S_IF;
          end
        end
      end
      S_WB: begin
        c.reg_we     = 1'b1;
        c.instr_done = 1'b1;
        if (opcode == OP_R) c.reg_dst = 2'd1;
        else if (is_lw)     c.wb_sel  = 2'd1;
      end
      default: state_d = S_IF;
    endcase
  end

  assign co = reset ? '0 : c;

  assign mem_req    = co.mem_req;
  assign mem_we     = co.mem_we;
  assign pc_we      = co.pc_we;
  assign npc_sel    = co.npc_sel;
  assign ir_we      = co.ir_we;
  assign reg_we     = co.reg_we;
  assign reg_dst    = co.reg_dst;
  assign wb_sel     = co.wb_sel;
  assign alu_src    = co.alu_src;
  assign alu_op     = co.alu_op;
  assign instr_done = co.instr_done;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (co.instr_done) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule
